// File: rtl/md_defs.sv
// Shared op codes and FSM encoding for the multiply/divide scheduler.
package md_defs;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MTHI  = 4'd5;
  localparam logic [3:0] MD_MTLO  = 4'd6;
  localparam logic [3:0] MD_MFHI  = 4'd7;
  localparam logic [3:0] MD_MFLO  = 4'd8;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_BUSY = 1'b1
  } md_state_t;

  // True for the ops that occupy the unit for a multi-cycle latency.
  function automatic logic is_seq_op(input logic [3:0] op);
    return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
  endfunction

endpackage

// File: rtl/md_compute.sv
// Combinational multiply/divide datapath: result for mult/multu/div/divu.
module md_compute
  import md_defs::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod;
  logic [31:0] mag_a;
  logic [31:0] mag_b;
  logic [31:0] div_b;
  logic [31:0] quo;
  logic [31:0] rem;
  logic        signed_div;

  // Divide on magnitudes, then restore signs; this also makes
  // 0x80000000 / -1 fall out as 0x80000000 with a zero remainder.
  always_comb begin
    signed_div = (op == MD_DIV);
    mag_a      = (signed_div && src_a[31]) ? (32'd0 - src_a) : src_a;
    mag_b      = (signed_div && src_b[31]) ? (32'd0 - src_b) : src_b;
    // Keep the divider free of X when the divisor is zero; the result is discarded.
    div_b      = (mag_b == 32'd0) ? 32'd1 : mag_b;
    quo        = mag_a / div_b;
    rem        = mag_a % div_b;
    if (signed_div && (src_a[31] != src_b[31])) quo = 32'd0 - quo;
    if (signed_div && src_a[31]) rem = 32'd0 - rem;
  end

  // Select the hi/lo pair for the current op.
  always_comb begin
    prod     = 64'd0;
    res_hi   = 32'd0;
    res_lo   = 32'd0;
    div_zero = 1'b0;
    unique case (op)
      MD_MULT: begin
        prod   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, src_a} * {32'd0, src_b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV, MD_DIVU: begin
        res_hi   = rem;
        res_lo   = quo;
        div_zero = (src_b == 32'd0);
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// HI/LO holder and countdown scheduler for the EX-stage multiply/divide unit.
module md_sched
  import md_defs::*;
#(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        op_valid,
  input  logic [3:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        d_uses_md,
  output logic        start,
  output logic        busy,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] rd_data
);

  md_state_t   state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic [31:0] pend_hi_q, pend_hi_d;
  logic [31:0] pend_lo_q, pend_lo_d;
  logic        pend_keep_q, pend_keep_d;
  logic        accept;
  logic [31:0] res_hi;
  logic [31:0] res_lo;
  logic        div_zero;

  md_compute u_compute (
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

  // A flush in the same cycle cancels any E-stage op, sequenced or not.
  assign accept  = (state_q == S_IDLE) && op_valid && !req;
  assign start   = accept && is_seq_op(op);
  assign busy    = (state_q == S_BUSY);
  assign stall   = d_uses_md && (start || busy);
  assign hi      = hi_q;
  assign lo      = lo_q;
  assign rd_data = (op == MD_MFHI) ? hi_q : (op == MD_MFLO) ? lo_q : 32'd0;

  // Next-state: launch, count down, commit, and mthi/mtlo writes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    hi_d        = hi_q;
    lo_d        = lo_q;
    pend_hi_d   = pend_hi_q;
    pend_lo_d   = pend_lo_q;
    pend_keep_d = pend_keep_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_BUSY;
          cnt_d       = ((op == MD_MULT) || (op == MD_MULTU)) ? 8'(MULT_CYCLES) : 8'(DIV_CYCLES);
          pend_hi_d   = res_hi;
          pend_lo_d   = res_lo;
          pend_keep_d = div_zero;
        end else if (accept && (op == MD_MTHI)) begin
          hi_d = src_a;
        end else if (accept && (op == MD_MTLO)) begin
          lo_d = src_a;
        end
      end
      S_BUSY: begin
        if (cnt_q == 8'd1) begin
          state_d = S_IDLE;
          cnt_d   = 8'd0;
          // Divide by zero still spends its latency but leaves HI/LO alone.
          if (!pend_keep_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and register update with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 8'd0;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      pend_hi_q   <= 32'd0;
      pend_lo_q   <= 32'd0;
      pend_keep_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      hi_q        <= hi_d;
      lo_q        <= lo_d;
      pend_hi_q   <= pend_hi_d;
      pend_lo_q   <= pend_lo_d;
      pend_keep_q <= pend_keep_d;
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Bench for md_sched: directed scenarios followed by random traffic, all
// checked every cycle against a cycle-count reference model.
module tb_md_sched;

  localparam int unsigned MC = 5;
  localparam int unsigned DC = 10;

  logic        clk = 1'b0;
  logic        reset, req, op_valid, d_uses_md;
  logic [3:0]  op;
  logic [31:0] src_a, src_b;
  logic        start, busy, stall;
  logic [31:0] hi, lo, rd_data;

  int checks = 0;
  int errors = 0;

  // Reference model state.
  logic [31:0] m_hi, m_lo, m_phi, m_plo;
  logic        m_keep;
  int          m_remain;

  md_sched #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .op_valid  (op_valid),
    .op        (op),
    .src_a     (src_a),
    .src_b     (src_b),
    .d_uses_md (d_uses_md),
    .start     (start),
    .busy      (busy),
    .stall     (stall),
    .hi        (hi),
    .lo        (lo),
    .rd_data   (rd_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic seq_op(input logic [3:0] o);
    return o >= 4'd1 && o <= 4'd4;
  endfunction

  // Architectural result from plain 64-bit arithmetic.
  task automatic model_result(input logic [3:0] o, input logic [31:0] a, input logic [31:0] b,
                              output logic [31:0] rh, output logic [31:0] rl, output logic keep);
    longint p, q, r;
    logic [63:0] u;
    keep = 1'b0;
    rh = 32'd0;
    rl = 32'd0;
    case (o)
      4'd1: begin
        p = longint'($signed(a)) * longint'($signed(b));
        u = p;
        rh = u[63:32];
        rl = u[31:0];
      end
      4'd2: begin
        u = {32'd0, a} * {32'd0, b};
        rh = u[63:32];
        rl = u[31:0];
      end
      4'd3, 4'd4: begin
        if (b == 32'd0) keep = 1'b1;
        else begin
          if (o == 4'd3) begin
            q = longint'($signed(a)) / longint'($signed(b));
            r = longint'($signed(a)) % longint'($signed(b));
          end else begin
            q = longint'({32'd0, a}) / longint'({32'd0, b});
            r = longint'({32'd0, a}) % longint'({32'd0, b});
          end
          u = q;
          rl = u[31:0];
          u = r;
          rh = u[31:0];
        end
      end
      default: ;
    endcase
  endtask

  // One clock: drive inputs, check outputs mid-cycle, advance model at the edge.
  task automatic cyc(input logic ov, input logic [3:0] o, input logic [31:0] a,
                     input logic [31:0] b, input logic rq, input logic du, input logic rst);
    logic e_busy, e_start;
    logic [31:0] rh, rl;
    logic kp;
    op_valid = ov; op = o; src_a = a; src_b = b; req = rq; d_uses_md = du; reset = rst;
    #4;
    e_busy  = m_remain > 0;
    e_start = !e_busy && ov && !rq && seq_op(o);
    chk("start", {31'd0, start}, {31'd0, e_start});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("stall", {31'd0, stall}, {31'd0, du & (e_start | e_busy)});
    chk("hi", hi, m_hi);
    chk("lo", lo, m_lo);
    if (ov) chk("rd_data", rd_data, (o == 4'd7) ? m_hi : (o == 4'd8) ? m_lo : 32'd0);
    @(posedge clk);
    if (rst) begin
      m_hi = 0; m_lo = 0; m_remain = 0;
    end else if (e_busy) begin
      m_remain--;
      if (m_remain == 0 && !m_keep) begin
        m_hi = m_phi; m_lo = m_plo;
      end
    end else if (e_start) begin
      model_result(o, a, b, rh, rl, kp);
      m_phi = rh; m_plo = rl; m_keep = kp;
      m_remain = (o <= 4'd2) ? int'(MC) : int'(DC);
    end else if (ov && !rq && o == 4'd5) m_hi = a;
    else if (ov && !rq && o == 4'd6) m_lo = a;
    #1;
  endtask

  task automatic idle(input int n, input logic du);
    for (int i = 0; i < n; i++) cyc(1'b0, 4'd0, 32'd0, 32'd0, 1'b0, du, 1'b0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      5: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0; m_keep = 0; m_remain = 0;
    op_valid = 0; op = 0; src_a = 0; src_b = 0; req = 0; d_uses_md = 0; reset = 1;
    @(posedge clk); #1;
    cyc(1'b0, 4'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    chk("reset_hi", hi, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);

    // mult -2 * 3 with a D-stage MD op stalling throughout.
    cyc(1'b1, 4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1, 1'b0);
    idle(MC + 1, 1'b1);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFA);

    cyc(1'b1, 4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(MC, 1'b0);
    chk("multu_hi", hi, 32'hFFFF_FFFE);
    chk("multu_lo", lo, 32'h0000_0001);

    cyc(1'b1, 4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    cyc(1'b1, 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'd0);

    // Divide by zero keeps prior HI/LO.
    cyc(1'b1, 4'd4, 32'd5, 32'd0, 1'b0, 1'b0, 1'b0);
    idle(DC, 1'b0);
    chk("divz_lo", lo, 32'h8000_0000);

    // Flush in the start cycle cancels the op.
    cyc(1'b1, 4'd1, 32'd7, 32'd7, 1'b1, 1'b0, 1'b0);
    idle(MC + 1, 1'b0);
    chk("req_lo", lo, 32'h8000_0000);

    // Flush mid-busy does not abort.
    cyc(1'b1, 4'd2, 32'd6, 32'd7, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 0, 0, 1'b1, 1'b0, 1'b0);
    idle(MC, 1'b0);
    chk("reqmid_lo", lo, 32'd42);

    // Reset during a divide discards it.
    cyc(1'b1, 4'd4, 32'd100, 32'd3, 1'b0, 1'b0, 1'b0);
    idle(2, 1'b0);
    cyc(1'b0, 4'd0, 0, 0, 1'b0, 1'b0, 1'b1);
    idle(DC, 1'b0);
    chk("rstdiv_lo", lo, 32'd0);

    cyc(1'b1, 4'd5, 32'h1234, 0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd7, 0, 0, 1'b0, 1'b0, 1'b0);
    chk("mfhi_hi", hi, 32'h0000_1234);

    // Random traffic; new ops only issue while the model says the unit is idle.
    for (int i = 0; i < 600; i++) begin
      logic ov;
      ov = (m_remain == 0) && ($urandom_range(0, 2) != 0);
      cyc(ov, 4'($urandom_range(0, 8)), pick(), pick(), $urandom_range(0, 7) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 60) == 0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
